// File: rtl/bcd_timestamp_decoder.sv
`default_nettype none
// bcd_timestamp_decoder: captures a BCD time word on an event strobe and converts
// it to a binary tick count, one digit per clock, MSD first. Rev 1.0

module bcd_timestamp_decoder #(
  parameter int DIGITS = 12,
  parameter int BIN_W  = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   time_bcd,
  input  logic                  trigger,
  output logic [BIN_W-1:0]      bin_time,
  output logic                  bin_valid,
  input  logic                  bin_ready,
  output logic                  busy,
  output logic                  bcd_error,
  output logic [7:0]            drop_count
);

  localparam int c_SR_W  = 4 * DIGITS;
  localparam int c_CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_SR_W-1:0]    r_shift;
  logic [BIN_W-1:0]     r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]     r_bin_time;
  logic                 r_bin_valid;
  logic                 r_busy;
  logic                 r_bcd_error;
  logic [7:0]           r_drop_count;

  logic [3:0]           w_digit;
  logic [BIN_W-1:0]     w_acc_x10;
  logic [BIN_W-1:0]     w_acc_step;
  logic                 w_last;
  logic                 w_handshake;
  logic                 w_capture;
  logic                 w_drop;

  always_comb begin
    w_digit     = r_shift[c_SR_W-1 -: 4];
    w_acc_x10   = (r_acc << 3) + (r_acc << 1);
    w_acc_step  = w_acc_x10 + BIN_W'(w_digit);
    w_last      = (r_cnt == c_CNT_W'(DIGITS - 1));
    w_handshake = r_bin_valid & bin_ready;
    // A trigger coinciding with the HOLD handshake is a fresh capture, not a drop.
    w_capture   = trigger & ((r_state == S_IDLE) | ((r_state == S_HOLD) & w_handshake));
    w_drop      = trigger & ~w_capture;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (trigger) w_state_nxt = S_CONVERT;
      S_CONVERT: if (w_last) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_handshake) w_state_nxt = w_capture ? S_CONVERT : S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bin_time  <= '0;
      r_bin_valid <= 1'b0;
      r_bcd_error <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_shift     <= time_bcd;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_bcd_error <= 1'b0;
      end else if (r_state == S_CONVERT) begin
        r_acc   <= w_acc_step;
        r_shift <= r_shift << 4;
        r_cnt   <= r_cnt + c_CNT_W'(1);
        if (w_digit > 4'd9) r_bcd_error <= 1'b1;
        if (w_last) r_bin_time <= w_acc_step;
      end
      if ((r_state == S_CONVERT) && w_last) begin
        r_bin_valid <= 1'b1;
      end else if (w_handshake) begin
        r_bin_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_count <= 8'd0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign bin_time   = r_bin_time;
  assign bin_valid  = r_bin_valid;
  assign busy       = r_busy;
  assign bcd_error  = r_bcd_error;
  assign drop_count = r_drop_count;

endmodule

`default_nettype wire
